accel_mac_engine: RTL and testbench

- Compute stage directly downstream of the peripheral's operand register file.
- Consumes the four 8-bit operand registers A–D on a start pulse.
- Runs a sequential shift-add multiply or multiply-accumulate, then presents a registered result with busy/done status.
- The register wrapper maps start/mode onto a control register and reads result/status back bytewise.

---
 rtl/accel_pkg.sv | 22 ++
 rtl/accel_mac_engine_if.sv | 28 ++
 rtl/accel_seq_mul.sv | 55 +++++
 rtl/accel_mac_engine.sv | 159 +++++++++++++++
 tb/tb_accel_mac_engine.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/accel_pkg.sv
// Shared constants and enumerations for the MAC accelerator compute stage.
package accel_pkg;

  localparam int unsigned DEF_OP_W   = 8;
  localparam int unsigned DEF_ACC_W  = 20;
  localparam int unsigned MUL_CYCLES = 8;

  typedef enum logic [1:0] {
    MODE_MUL = 2'd0,
    MODE_DOT = 2'd1,
    MODE_MAC = 2'd2,
    MODE_CLR = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL1 = 2'd1,
    MUL2 = 2'd2,
    FIN  = 2'd3
  } state_e;

endpackage

// File: rtl/accel_mac_engine_if.sv
// Request/result bundle between the operand register file and the MAC engine.
interface accel_mac_engine_if #(
  parameter int unsigned OP_W  = 8,
  parameter int unsigned ACC_W = 20
) ();

  logic             start;
  logic [1:0]       mode;
  logic [OP_W-1:0]  op_a;
  logic [OP_W-1:0]  op_b;
  logic [OP_W-1:0]  op_c;
  logic [OP_W-1:0]  op_d;
  logic [ACC_W-1:0] result;
  logic             busy;
  logic             done;
  logic             ovf;

  modport master (
    output start, mode, op_a, op_b, op_c, op_d,
    input  result, busy, done, ovf
  );

  modport slave (
    input  start, mode, op_a, op_b, op_c, op_d,
    output result, busy, done, ovf
  );

endinterface

// File: rtl/accel_seq_mul.sv
// LSB-first shift-add multiplier: load clears the product, each step retires one multiplier bit.
module accel_seq_mul
  import accel_pkg::*;
#(
  parameter int unsigned OP_W = DEF_OP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [OP_W-1:0]   mcand_i,
  input  logic [OP_W-1:0]   mplier_i,
  output logic [2*OP_W-1:0] prod_next_o
);

  localparam int unsigned PW = 2 * OP_W;

  logic [PW-1:0]   mcand_q, mcand_d;
  logic [OP_W-1:0] mplier_q, mplier_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic [PW-1:0]   prod_step;

  // Product as it will be after the current step; lets the caller grab the final bit's sum
  // in the same cycle it reloads new operands.
  assign prod_step   = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign prod_next_o = prod_step;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    if (load_i) begin
      mcand_d  = {{OP_W{1'b0}}, mcand_i};
      mplier_d = mplier_i;
      prod_d   = '0;
    end else if (step_i) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      prod_d   = prod_step;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

endmodule

// File: rtl/accel_mac_engine.sv
// MAC engine: sequences one shared shift-add multiplier through A*B and optionally C*D,
// then folds the products into result/accumulator with a sticky wrap flag.
module accel_mac_engine
  import accel_pkg::*;
#(
  parameter int unsigned OP_W  = DEF_OP_W,
  parameter int unsigned ACC_W = DEF_ACC_W
) (
  input logic                clk,
  input logic                rst_n,
  accel_mac_engine_if.slave  bus
);

  localparam int unsigned PW   = 2 * OP_W;
  localparam int unsigned ZW   = ACC_W - PW;
  localparam int unsigned CntW = $clog2(MUL_CYCLES);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [OP_W-1:0]  c_q, c_d, d_q, d_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]    prod1_q, prod1_d, prod2_q, prod2_d;
  logic [ACC_W-1:0] acc_q, acc_d, result_q, result_d;
  logic             ovf_q, ovf_d;

  logic             mul_load, mul_step;
  logic [OP_W-1:0]  mul_mcand, mul_mplier;
  logic [PW-1:0]    mul_prod;
  logic             cnt_last;
  logic [ACC_W:0]   mac_sum;
  logic [ACC_W-1:0] dot_sum;

  accel_seq_mul #(
    .OP_W (OP_W)
  ) u_mul (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (mul_load),
    .step_i      (mul_step),
    .mcand_i     (mul_mcand),
    .mplier_i    (mul_mplier),
    .prod_next_o (mul_prod)
  );

  assign cnt_last = (cnt_q == CntW'(MUL_CYCLES - 1));
  assign mac_sum  = {1'b0, acc_q} + {{(ZW + 1){1'b0}}, prod1_q};
  assign dot_sum  = {{ZW{1'b0}}, prod1_q} + {{ZW{1'b0}}, prod2_q};

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    c_d        = c_q;
    d_d        = d_q;
    cnt_d      = cnt_q;
    prod1_d    = prod1_q;
    prod2_d    = prod2_q;
    acc_d      = acc_q;
    result_d   = result_q;
    ovf_d      = ovf_q;
    mul_load   = 1'b0;
    mul_step   = 1'b0;
    mul_mcand  = bus.op_a;
    mul_mplier = bus.op_b;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          mode_d = mode_e'(bus.mode);
          c_d    = bus.op_c;
          d_d    = bus.op_d;
          cnt_d  = '0;
          if (mode_e'(bus.mode) == MODE_CLR) begin
            state_d = FIN;
          end else begin
            state_d  = MUL1;
            mul_load = 1'b1;
          end
        end
      end
      MUL1: begin
        mul_step = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_last) begin
          prod1_d = mul_prod;
          cnt_d   = '0;
          if (mode_q == MODE_DOT) begin
            // Reload overrides the step; its final sum is already captured in prod1.
            mul_load   = 1'b1;
            mul_mcand  = c_q;
            mul_mplier = d_q;
            state_d    = MUL2;
          end else begin
            state_d = FIN;
          end
        end
      end
      MUL2: begin
        mul_step = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_last) begin
          prod2_d = mul_prod;
          cnt_d   = '0;
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
        unique case (mode_q)
          MODE_MUL: result_d = {{ZW{1'b0}}, prod1_q};
          MODE_DOT: result_d = dot_sum;
          MODE_MAC: begin
            acc_d    = mac_sum[ACC_W-1:0];
            result_d = mac_sum[ACC_W-1:0];
            if (mac_sum[ACC_W]) ovf_d = 1'b1;
          end
          MODE_CLR: begin
            acc_d    = '0;
            ovf_d    = 1'b0;
            result_d = '0;
          end
          default: result_d = result_q;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mode_q   <= MODE_MUL;
      c_q      <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      prod1_q  <= '0;
      prod2_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      c_q      <= c_d;
      d_q      <= d_d;
      cnt_q    <= cnt_d;
      prod1_q  <= prod1_d;
      prod2_q  <= prod2_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.result = result_q;
  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == FIN);
  assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_accel_mac_engine.sv
// Self-checking bench for accel_mac_engine: directed cases plus randomized operations
// checked cycle by cycle against an arithmetic reference model.
module tb_accel_mac_engine;
  import accel_pkg::*;

  localparam int unsigned OpW  = 8;
  localparam int unsigned AccW = 20;
  localparam int unsigned AccMod = 1 << AccW;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  accel_mac_engine_if #(.OP_W(OpW), .ACC_W(AccW)) bus ();

  accel_mac_engine #(
    .OP_W  (OpW),
    .ACC_W (AccW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int unsigned m_acc = 0;
  int unsigned m_res = 0;
  logic        m_ovf = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_junk(input bit keep_start);
    bus.op_a  = 8'($urandom);
    bus.op_b  = 8'($urandom);
    bus.op_c  = 8'($urandom);
    bus.op_d  = 8'($urandom);
    bus.mode  = 2'($urandom);
    bus.start = keep_start ? 1'b1 : 1'($urandom);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      drive_junk(1'b0);
      bus.start = 1'b0;
      @(negedge clk);
      check_val("idle_busy", {31'd0, bus.busy}, 32'd0);
      check_val("idle_done", {31'd0, bus.done}, 32'd0);
      check_val("idle_result", {12'd0, bus.result}, m_res);
    end
  endtask

  // Called at a negedge while the DUT is idle; returns at the negedge of the first
  // cycle after FIN, having checked every cycle in between.
  task automatic run_op(input logic [1:0] mode, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d, input bit keep_start);
    int          lat;
    int unsigned prev;
    prev = m_res;
    case (mode)
      2'd0: m_res = a * b;
      2'd1: m_res = a * b + c * d;
      2'd2: begin
        m_acc = m_acc + a * b;
        if (m_acc >= AccMod) begin
          m_acc = m_acc - AccMod;
          m_ovf = 1'b1;
        end
        m_res = m_acc;
      end
      default: begin
        m_acc = 0;
        m_ovf = 1'b0;
        m_res = 0;
      end
    endcase
    lat = (mode == 2'd1) ? 17 : (mode == 2'd3) ? 1 : 9;

    bus.start = 1'b1;
    bus.mode  = mode;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.op_c  = c;
    bus.op_d  = d;
    for (int j = 1; j <= lat + 1; j++) begin
      @(negedge clk);
      if (j <= lat) begin
        check_val("busy", {31'd0, bus.busy}, 32'd1);
        check_val("done", {31'd0, bus.done}, (j == lat) ? 32'd1 : 32'd0);
        check_val("result_hold", {12'd0, bus.result}, prev);
        // Operand/mode/start noise while busy must not disturb the operation.
        drive_junk(keep_start);
      end else begin
        check_val("post_busy", {31'd0, bus.busy}, 32'd0);
        check_val("post_done", {31'd0, bus.done}, 32'd0);
        check_val("result", {12'd0, bus.result}, m_res);
        check_val("ovf", {31'd0, bus.ovf}, {31'd0, m_ovf});
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.mode  = 2'd0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    bus.op_c  = '0;
    bus.op_d  = '0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_val("rst_done", {31'd0, bus.done}, 32'd0);
    check_val("rst_result", {12'd0, bus.result}, 32'd0);
    check_val("rst_ovf", {31'd0, bus.ovf}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    run_op(2'd0, 8'd13, 8'd11, 8'd0, 8'd0, 1'b0);
    run_op(2'd1, 8'd255, 8'd255, 8'd255, 8'd255, 1'b0);
    check_val("dot_max", {12'd0, bus.result}, 32'h1FC02);

    run_op(2'd3, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    for (int i = 1; i <= 27; i++) begin
      run_op(2'd2, 8'd200, 8'd200, 8'd0, 8'd0, 1'b0);
      if (i == 26) check_val("mac26", {12'd0, bus.result}, 32'd1040000);
      if (i == 27) begin
        check_val("mac27", {12'd0, bus.result}, 32'd31424);
        check_val("mac27_ovf", {31'd0, bus.ovf}, 32'd1);
      end
    end
    run_op(2'd3, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    check_val("clr_ovf", {31'd0, bus.ovf}, 32'd0);

    run_op(2'd0, 8'd3, 8'd5, 8'd0, 8'd0, 1'b0);
    idle(1);

    // Reset in the middle of a dot-product operation.
    bus.start = 1'b1;
    bus.mode  = 2'd1;
    bus.op_a  = 8'd9;
    bus.op_b  = 8'd9;
    bus.op_c  = 8'd9;
    bus.op_d  = 8'd9;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      check_val("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
      bus.start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_val("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    check_val("mid_rst_done", {31'd0, bus.done}, 32'd0);
    check_val("mid_rst_result", {12'd0, bus.result}, 32'd0);
    check_val("mid_rst_ovf", {31'd0, bus.ovf}, 32'd0);
    m_acc = 0;
    m_res = 0;
    m_ovf = 1'b0;
    rst_n = 1'b1;
    run_op(2'd0, 8'd2, 8'd9, 8'd0, 8'd0, 1'b0);

    // start held high: back-to-back with one idle cycle between FIN and next busy.
    for (int i = 0; i < 3; i++) run_op(2'd0, 8'd1, 8'd1, 8'd1, 8'd1, 1'b1);
    idle(2);

    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      idle(int'($urandom_range(0, 2)));
    end
    bus.start = 1'b0;
    idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
